// File: rtl/pll_lock_reset_sequencer.sv
// PLL reset pulse generator, lock debouncer and staggered downstream reset release on refclk.
// Define RSTSEQ_LOCK_TIMEOUT_EN to re-pulse the PLL reset when lock does not arrive in time.
module pll_lock_reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int STAGE_GAP_CYCLES    = 16,
  parameter int NUM_STAGES          = 3,
  parameter int PLL_RST_CYCLES      = 8,
  parameter int LOCK_TIMEOUT_CYCLES = 500000
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  pll_locked,
  output logic                  pll_rst,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  ready,
  output logic [7:0]            relock_count
);

  localparam logic [2:0] S_PLL_RESET = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_RELEASE   = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;

  localparam int RW = $clog2(PLL_RST_CYCLES + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int GW = $clog2(STAGE_GAP_CYCLES + 1);
  localparam logic [RW-1:0] R_LAST = RW'(PLL_RST_CYCLES - 1);
  localparam logic [SW-1:0] L_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [GW-1:0] G_LAST = GW'(STAGE_GAP_CYCLES - 1);

  logic                  sync_p0, lk_s;
  logic [2:0]            state_q, state_d;
  logic [RW-1:0]         rst_cnt_q, rst_cnt_d;
  logic [SW-1:0]         stab_cnt_q, stab_cnt_d;
  logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
  logic                  pll_rst_d, ready_d, loss;
  logic [NUM_STAGES-1:0] stage_d, stage_next;
  logic [7:0]            relock_d;

`ifdef RSTSEQ_LOCK_TIMEOUT_EN
  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    stab_cnt_d = stab_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    pll_rst_d  = pll_rst;
    stage_d    = stage_rst_n;
    ready_d    = ready;
    relock_d   = relock_count;
    loss       = 1'b0;
    stage_next = (stage_rst_n << 1) | NUM_STAGES'(1);
`ifdef RSTSEQ_LOCK_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
`endif
    case (state_q)
      S_PLL_RESET: begin
        pll_rst_d = 1'b1;
        if (rst_cnt_q == R_LAST) begin
          pll_rst_d = 1'b0;
          state_d   = S_WAIT_LOCK;
        end else begin
          rst_cnt_d = rst_cnt_q + RW'(1);
        end
      end
      S_WAIT_LOCK: begin
        if (lk_s) begin
          state_d = S_STABLE;
`ifdef RSTSEQ_LOCK_TIMEOUT_EN
        end else if (tmo_cnt_q == T_LAST) begin
          pll_rst_d = 1'b1;
          state_d   = S_PLL_RESET;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
`endif
        end
      end
      S_STABLE: begin
        if (!lk_s) begin
          state_d = S_WAIT_LOCK;
        end else if (stab_cnt_q == L_LAST) begin
          stage_d = NUM_STAGES'(1);
          if (NUM_STAGES == 1) begin
            ready_d = 1'b1;
            state_d = S_RUN;
          end else begin
            state_d = S_RELEASE;
          end
        end else begin
          stab_cnt_d = stab_cnt_q + SW'(1);
        end
      end
      S_RELEASE: begin
        // Loss is checked first so a dropping lock never releases another stage.
        if (!lk_s) begin
          loss = 1'b1;
        end else if (gap_cnt_q == G_LAST) begin
          stage_d   = stage_next;
          gap_cnt_d = '0;
          if (stage_next == '1) begin
            ready_d = 1'b1;
            state_d = S_RUN;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      S_RUN: begin
        if (!lk_s) loss = 1'b1;
      end
      default: state_d = S_PLL_RESET;
    endcase

    if (loss) begin
      stage_d   = '0;
      ready_d   = 1'b0;
      pll_rst_d = 1'b1;
      relock_d  = sat_inc8(relock_count);
      state_d   = S_PLL_RESET;
    end

    if (state_d != state_q) begin
      rst_cnt_d  = '0;
      stab_cnt_d = '0;
      gap_cnt_d  = '0;
`ifdef RSTSEQ_LOCK_TIMEOUT_EN
      tmo_cnt_d  = '0;
`endif
    end
  end

  // Synchronizer (p0 -> lk_s) and registered FSM outputs
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      sync_p0      <= 1'b0;
      lk_s         <= 1'b0;
      state_q      <= S_PLL_RESET;
      rst_cnt_q    <= '0;
      stab_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      pll_rst      <= 1'b1;
      stage_rst_n  <= '0;
      ready        <= 1'b0;
      relock_count <= 8'd0;
`ifdef RSTSEQ_LOCK_TIMEOUT_EN
      tmo_cnt_q    <= '0;
`endif
    end else begin
      sync_p0      <= pll_locked;
      lk_s         <= sync_p0;
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      stab_cnt_q   <= stab_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      pll_rst      <= pll_rst_d;
      stage_rst_n  <= stage_d;
      ready        <= ready_d;
      relock_count <= relock_d;
`ifdef RSTSEQ_LOCK_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
`endif
    end
  end

endmodule
